// File: rtl/ahb_panic_arbiter_2m.sv
// ahb_panic_arbiter_2m: two-requester AHB5 arbiter, req0 priority with a wait-timer boost for req1
module ahb_panic_arbiter_2m #(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int PANIC_CYCLES = 8,
  parameter int W_WAIT       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_aph_req,
  input  logic [W_ADDR-1:0] req0_haddr,
  input  logic              req0_hwrite,
  input  logic [2:0]        req0_hsize,
  input  logic [3:0]        req0_hprot,
  input  logic              req0_excl,
  input  logic [W_DATA-1:0] req0_wdata,
  output logic              req0_aph_ready,
  output logic              req0_dph_ready,
  output logic              req0_dph_err,
  output logic              req0_dph_exokay,
  input  logic              req1_aph_req,
  input  logic [W_ADDR-1:0] req1_haddr,
  input  logic              req1_hwrite,
  input  logic [2:0]        req1_hsize,
  input  logic [3:0]        req1_hprot,
  input  logic              req1_excl,
  input  logic [W_DATA-1:0] req1_wdata,
  output logic              req1_aph_ready,
  output logic              req1_dph_ready,
  output logic              req1_dph_err,
  output logic              req1_dph_exokay,
  output logic [W_DATA-1:0] rdata,
  output logic [W_ADDR-1:0] haddr,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [3:0]        hprot,
  output logic              hexcl,
  output logic [1:0]        htrans,
  output logic [7:0]        hmaster,
  output logic [2:0]        hburst,
  output logic              hmastlock,
  output logic [W_DATA-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic              hexokay,
  input  logic [W_DATA-1:0] hrdata,
  output logic              panic_active
);
  localparam logic [W_WAIT-1:0] PANIC_LIM = W_WAIT'(PANIC_CYCLES);
  logic              hold_aph, active_dph0, active_dph1, panic, err_first, dph0, dph1;
  logic [1:0]        gnt, gnt_prev;
  logic [W_WAIT-1:0] wait_cnt;
  always_comb begin
    err_first = hresp & ~hready;
    panic = (PANIC_CYCLES != 0) && (wait_cnt == PANIC_LIM);
    // a stalled address phase keeps its owner even over a pending boost
    gnt = rst ? 2'b00 : hold_aph ? gnt_prev : err_first ? 2'b00 :
          (panic & req1_aph_req) ? 2'b10 : req0_aph_req ? 2'b01 :
          req1_aph_req ? 2'b10 : 2'b00;
    htrans = gnt[1] | gnt[0] ? 2'b10 : 2'b00;
    haddr  = gnt[1] ? req1_haddr : gnt[0] ? req0_haddr : '0;
    hwrite = gnt[1] ? req1_hwrite : gnt[0] ? req0_hwrite : 1'b0;
    hsize  = gnt[1] ? req1_hsize : gnt[0] ? req0_hsize : 3'b000;
    hprot  = gnt[1] ? req1_hprot : gnt[0] ? req0_hprot : 4'h0;
    hexcl  = gnt[1] ? req1_excl : gnt[0] ? req0_excl : 1'b0;
    hmaster = {7'd0, gnt[1]};
    hburst = 3'b000;
    hmastlock = 1'b0;
    dph0 = active_dph0 & ~rst;
    dph1 = active_dph1 & ~rst;
    hwdata = rst ? '0 : active_dph1 ? req1_wdata : req0_wdata;
    req0_aph_ready = gnt[0] & hready;
    req1_aph_ready = gnt[1] & hready;
    req0_dph_ready = dph0 & hready;
    req1_dph_ready = dph1 & hready;
    req0_dph_err = dph0 & hresp;
    req1_dph_err = dph1 & hresp;
    req0_dph_exokay = dph0 & hexokay;
    req1_dph_exokay = dph1 & hexokay;
    rdata = hrdata;
    panic_active = panic & ~rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_aph <= 1'b0;
      gnt_prev <= 2'b00;
      active_dph0 <= 1'b0;
      active_dph1 <= 1'b0;
      wait_cnt <= '0;
    end else begin
      hold_aph <= htrans[1] & ~hready & ~hresp;
      gnt_prev <= gnt;
      if (hready) {active_dph1, active_dph0} <= gnt;
      wait_cnt <= (~req1_aph_req | req1_aph_ready) ? '0 :
                  (wait_cnt == PANIC_LIM) ? wait_cnt : wait_cnt + W_WAIT'(1);
    end
  end
endmodule

// File: tb/tb_ahb_panic_arbiter_2m.sv
// tb_ahb_panic_arbiter_2m: directed vector table plus hand sequences for the arbiter
module tb_ahb_panic_arbiter_2m;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, q0, q1, hready, hresp, hexokay;
  logic [31:0] a0, a1, w0, w1, hrdata;
  logic        r0_aph, r0_dph, r0_err, r0_exok, r1_aph, r1_dph, r1_err, r1_exok;
  logic [31:0] rdata, haddr, hwdata;
  logic        hwrite, hexcl, hmastlock, panic_active;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [7:0]  hmaster;
  logic        b_r0_aph, b_r0_dph, b_r0_err, b_r0_exok, b_r1_aph, b_r1_dph, b_r1_err, b_r1_exok;
  logic [31:0] b_rdata, b_haddr, b_hwdata;
  logic        b_hwrite, b_hexcl, b_hmastlock, b_panic;
  logic [2:0]  b_hsize, b_hburst;
  logic [3:0]  b_hprot;
  logic [1:0]  b_htrans;
  logic [7:0]  b_hmaster;
  int n_chk = 0;
  int n_fail = 0;

  ahb_panic_arbiter_2m #(.PANIC_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req0_aph_req(q0), .req0_haddr(a0), .req0_hwrite(1'b1), .req0_hsize(3'b010),
    .req0_hprot(4'h3), .req0_excl(1'b0), .req0_wdata(w0),
    .req0_aph_ready(r0_aph), .req0_dph_ready(r0_dph), .req0_dph_err(r0_err), .req0_dph_exokay(r0_exok),
    .req1_aph_req(q1), .req1_haddr(a1), .req1_hwrite(1'b0), .req1_hsize(3'b001),
    .req1_hprot(4'hA), .req1_excl(1'b1), .req1_wdata(w1),
    .req1_aph_ready(r1_aph), .req1_dph_ready(r1_dph), .req1_dph_err(r1_err), .req1_dph_exokay(r1_exok),
    .rdata(rdata), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hexcl(hexcl),
    .htrans(htrans), .hmaster(hmaster), .hburst(hburst), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hexokay(hexokay), .hrdata(hrdata), .panic_active(panic_active)
  );

  ahb_panic_arbiter_2m #(.PANIC_CYCLES(0)) dut_strict (
    .clk(clk), .rst(rst),
    .req0_aph_req(q0), .req0_haddr(a0), .req0_hwrite(1'b1), .req0_hsize(3'b010),
    .req0_hprot(4'h3), .req0_excl(1'b0), .req0_wdata(w0),
    .req0_aph_ready(b_r0_aph), .req0_dph_ready(b_r0_dph), .req0_dph_err(b_r0_err), .req0_dph_exokay(b_r0_exok),
    .req1_aph_req(q1), .req1_haddr(a1), .req1_hwrite(1'b0), .req1_hsize(3'b001),
    .req1_hprot(4'hA), .req1_excl(1'b1), .req1_wdata(w1),
    .req1_aph_ready(b_r1_aph), .req1_dph_ready(b_r1_dph), .req1_dph_err(b_r1_err), .req1_dph_exokay(b_r1_exok),
    .rdata(b_rdata), .haddr(b_haddr), .hwrite(b_hwrite), .hsize(b_hsize), .hprot(b_hprot), .hexcl(b_hexcl),
    .htrans(b_htrans), .hmaster(b_hmaster), .hburst(b_hburst), .hmastlock(b_hmastlock), .hwdata(b_hwdata),
    .hready(hready), .hresp(hresp), .hexokay(hexokay), .hrdata(hrdata), .panic_active(b_panic)
  );

  typedef struct {
    logic        rst, q0, q1, hrdy, hrsp;
    logic [31:0] a0, a1, w0, w1;
    logic [1:0]  e_trans;
    logic        e_mst;
    logic [31:0] e_addr, e_wdata;
    logic [5:0]  e_hs;
    logic        e_pan;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic r, logic x0, logic x1, logic hr, logic hs_in,
                              logic [31:0] ad0, logic [31:0] ad1, logic [31:0] d0, logic [31:0] d1,
                              logic [1:0] et, logic em, logic [31:0] ea, logic [31:0] ew,
                              logic [5:0] ehs, logic ep);
    vec_t v;
    v.rst = r; v.q0 = x0; v.q1 = x1; v.hrdy = hr; v.hrsp = hs_in;
    v.a0 = ad0; v.a1 = ad1; v.w0 = d0; v.w1 = d1;
    v.e_trans = et; v.e_mst = em; v.e_addr = ea; v.e_wdata = ew; v.e_hs = ehs; v.e_pan = ep;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    logic [8:0] e_attr;
    int seen_panic;
    rst = 1'b1; q0 = 0; q1 = 0; hready = 1; hresp = 0; hexokay = 0;
    a0 = 0; a1 = 0; w0 = 0; w1 = 0; hrdata = 0;
    // reset with both requesting: everything forced idle
    add(1,1,1,1,0, 'h100,'h300,0,0, 0,0,0,0, 6'b000000,0);
    add(1,1,1,1,0, 'h100,'h300,0,0, 0,0,0,0, 6'b000000,0);
    // req0 alone, three back-to-back writes
    add(0,1,0,1,0, 'h100,'h300,0,0,     2,0,'h100,0,     6'b000001,0);
    add(0,1,0,1,0, 'h104,'h300,'hA0,0,  2,0,'h104,'hA0,  6'b000011,0);
    add(0,1,0,1,0, 'h108,'h300,'hA1,0,  2,0,'h108,'hA1,  6'b000011,0);
    add(0,0,0,1,0, 'h108,'h300,'hA2,0,  0,0,0,'hA2,      6'b000010,0);
    // both requesting: 8 req0 grants, boosted req1, then req0 again
    add(0,1,1,1,0, 'h200,'h300,'h22,'h11, 2,0,'h200,'h22, 6'b000001,0);
    for (int i = 0; i < 7; i++) add(0,1,1,1,0, 'h200,'h300,'h22,'h11, 2,0,'h200,'h22, 6'b000011,0);
    add(0,1,1,1,0, 'h200,'h300,'h22,'h11, 2,1,'h300,'h22, 6'b001010,1);
    add(0,1,1,1,0, 'h200,'h300,'h22,'h11, 2,0,'h200,'h11, 6'b010001,0);
    // req0 stalled at 0x2000 while req1 reaches panic
    for (int i = 0; i < 6; i++) add(0,1,1,1,0, 'h200,'h300,'h22,'h11, 2,0,'h200,'h22, 6'b000011,0);
    add(0,1,1,0,0, 'h2000,'h300,'h22,'h11, 2,0,'h2000,'h22, 6'b000000,0);
    add(0,1,1,0,0, 'h2000,'h300,'h22,'h11, 2,0,'h2000,'h22, 6'b000000,1);
    add(0,1,1,0,0, 'h2000,'h300,'h22,'h11, 2,0,'h2000,'h22, 6'b000000,1);
    add(0,1,1,1,0, 'h2000,'h300,'h22,'h11, 2,0,'h2000,'h22, 6'b000011,1);
    add(0,1,1,1,0, 'h204,'h300,'h22,'h11,  2,1,'h300,'h22,  6'b001010,1);
    // two-cycle error on req1's data phase
    add(0,1,0,0,1, 'h204,'h300,'h22,'h11, 0,0,0,'h11,      6'b100000,0);
    add(0,1,0,1,1, 'h204,'h300,'h22,'h11, 2,0,'h204,'h11,  6'b110001,0);
    add(0,0,0,1,0, 'h204,'h300,'h22,'h11, 0,0,0,'h22,      6'b000010,0);
    // req1 aph stalled with wait count 5, then reset
    add(0,1,1,1,0, 'h200,'h300,'h22,'h11, 2,0,'h200,'h22, 6'b000001,0);
    for (int i = 0; i < 3; i++) add(0,1,1,1,0, 'h200,'h300,'h22,'h11, 2,0,'h200,'h22, 6'b000011,0);
    add(0,0,1,0,0, 'h200,'h300,'h22,'h11, 2,1,'h300,'h22, 6'b000000,0);
    add(1,0,1,0,0, 'h200,'h300,'h22,'h11, 0,0,0,0,        6'b000000,0);
    // counter restarted from 0: panic only after 8 more req0 grants
    add(0,1,1,1,0, 'h200,'h300,'h22,'h11, 2,0,'h200,'h22, 6'b000001,0);
    for (int i = 0; i < 7; i++) add(0,1,1,1,0, 'h200,'h300,'h22,'h11, 2,0,'h200,'h22, 6'b000011,0);
    add(0,1,1,1,0, 'h200,'h300,'h22,'h11, 2,1,'h300,'h22, 6'b001010,1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; q0 = vecs[i].q0; q1 = vecs[i].q1;
      hready = vecs[i].hrdy; hresp = vecs[i].hrsp;
      a0 = vecs[i].a0; a1 = vecs[i].a1; w0 = vecs[i].w0; w1 = vecs[i].w1;
      #1;
      e_attr = (vecs[i].e_trans == 2'b10) ?
               (vecs[i].e_mst ? {1'b0, 3'b001, 4'hA, 1'b1} : {1'b1, 3'b010, 4'h3, 1'b0}) : 9'd0;
      chk("htrans", i, 32'(htrans), 32'(vecs[i].e_trans));
      chk("hmaster", i, 32'(hmaster), 32'(vecs[i].e_mst));
      chk("haddr", i, haddr, vecs[i].e_addr);
      chk("hwdata", i, hwdata, vecs[i].e_wdata);
      chk("handshake", i, 32'({r1_err, r1_dph, r1_aph, r0_err, r0_dph, r0_aph}), 32'(vecs[i].e_hs));
      chk("panic_active", i, 32'(panic_active), 32'(vecs[i].e_pan));
      chk("attr", i, 32'({hwrite, hsize, hprot, hexcl}), 32'(e_attr));
    end

    // exclusive okay and read data pass-through on req0's data phase
    @(negedge clk); rst = 1; q0 = 0; q1 = 0; hready = 1; hresp = 0;
    @(negedge clk); rst = 0; q0 = 1;
    @(negedge clk); q0 = 0; hexokay = 1; hrdata = 32'hCAFE_F00D;
    #1;
    chk("exokay", 0, 32'({r1_exok, r0_exok}), 32'h1);
    chk("rdata", 0, rdata, 32'hCAFE_F00D);
    chk("hburst_lock", 0, 32'({hburst, hmastlock}), 32'h0);
    @(negedge clk); hexokay = 0;
    #1;
    chk("exokay_idle", 0, 32'({r1_exok, r0_exok}), 32'h0);

    // strict priority instance never serves req1 while req0 keeps requesting
    seen_panic = 0;
    @(negedge clk); q0 = 1; q1 = 1; a0 = 32'h400; a1 = 32'h500; hready = 1;
    for (int i = 0; i < 50; i++) begin
      #1;
      chk("strict_hmaster", i, 32'({b_htrans, b_hmaster}), 32'({2'b10, 8'h00}));
      chk("strict_panic", i, 32'(b_panic), 32'h0);
      if (panic_active) seen_panic++;
      @(negedge clk);
    end
    chk("boost_seen_in_default", 0, 32'(seen_panic > 0), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
